reaction_ctrl_fsm: RTL and testbench
====================================

Name: reaction_ctrl_fsm

Overview:
- Control unit for the reaction-timer game.
- Sequences idle → random wait → stimulus LED → millisecond timing → result, and produces BCD result digits and a display mode for the downstream 7-segment scanner.
- Sits between the debounced button inputs and the display multiplexer; contains no display scanning.

Parameters:
- TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz clock); minimum 2.
- MIN_DELAY_MS, 2000, fixed part of the random pre-stimulus delay, in ms.
- RAND_BITS, 11, LFSR bits added to the delay: random part is 0..2^RAND_BITS-1 ms.
- TIMEOUT_MS, 1000, reaction count at which the block gives up; must be ≤ 9999.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  debounced level; a rising edge is an event
- stop  in  1  debounced level; a rising edge is an event
- clear  in  1  debounced level; a rising edge is an event
- led  out  1  stimulus LED; high only in TIMING
- bcd  out  16  result digits {thousands, hundreds, tens, ones}, 4 bits each
- disp_mode  out  2  0=IDLE_MSG ("HI"), 1=COUNT (show bcd), 2=CHEAT, 3=BLANK
- busy  out  1  high in WAIT and TIMING

Behaviour:
- Clock and reset: single clock domain. Async reset_n low forces state=IDLE, led=0, bcd=0, disp_mode=0, busy=0, tick counter=0, edge registers=0. LFSR resets to 1, never 0.
- Edge detection: one register per button; event = in & ~in_q. Events act on the next clock edge, so outputs lag the button edge by 1 cycle.
- Event priority, when several occur in one cycle: clear > stop > start.
- LFSR: 16-bit maximal Fibonacci, taps 16,15,13,4. Free-runs every cycle in all states.
- Delay latch: on IDLE→WAIT, delay_ms = MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
- Prescaler: counts 0..TICK_DIV-1. It is cleared on every state entry. tick is a 1-cycle pulse when it reaches TICK_DIV-1.
- IDLE: disp_mode=0, led=0. start → WAIT (load delay, clear the ms counter). stop ignored.
- WAIT: disp_mode=3, busy=1.
  - ms counter increments on tick.
  - When ms == delay_ms-1 and tick occurs → TIMING, with the BCD counter cleared.
  - stop → CHEAT.
  - clear → IDLE.
  - start ignored.
- TIMING: led=1, busy=1, disp_mode=1.
  - 4-digit BCD counter increments on tick, carrying digit-wise 9→0. bcd shows the live count.
  - stop → DONE; the count is frozen at its value before that edge. A tick coinciding with stop is discarded.
  - Reaching TIMEOUT_MS → DONE with bcd = TIMEOUT_MS in BCD.
  - clear → IDLE.
- DONE: led=0, disp_mode=1, bcd held. clear → IDLE (bcd=0). start → WAIT (new delay). stop ignored.
- CHEAT: led=0, disp_mode=2, bcd=9999. Only clear leaves, → IDLE with bcd=0.
- Outputs are registered or decoded purely from state; no combinational path from any input to any output.
- No illegal states: default branch → IDLE.

Decomposition:
- Package reaction_pkg:
  - typedef enum state_t {IDLE, WAIT, TIMING, DONE, CHEAT}
  - typedef enum disp_mode_t
  - LFSR tap constant
  - function to convert a binary constant (TIMEOUT_MS) to BCD
- Sub-module bcd_counter4:
  - Ports: clk, reset_n, clr, inc, q[15:0], at_max.
  - Synchronous clear; increments on inc with digit carry.
  - Reused by the display and other timers.

Test Plan (bench runs TICK_DIV=4, MIN_DELAY_MS=3, RAND_BITS=2, TIMEOUT_MS=12):
- Reset, then idle 20 cycles → led=0, bcd=0, disp_mode=0, busy=0; LFSR never 0.
- start pulse → busy=1 and disp_mode=3 the next cycle. led rises exactly (3+lfsr[1:0])×4 cycles after WAIT entry (model the LFSR in the bench). stop 22 cycles after led rises → 5 ticks counted, bcd=16'h0005, disp_mode=1, led=0.
- stop during WAIT → CHEAT: bcd=16'h9999, disp_mode=2. A following start has no effect. clear → IDLE with bcd=0.
- No stop in TIMING → after 12 ticks (48 cycles) state=DONE, bcd=16'h0012, led=0.
- In TIMING, assert clear and stop on the same edge → IDLE, bcd=0. Then a stop and start on the same edge in DONE → start wins, WAIT entered.
- Assert reset_n low mid-TIMING, between clock edges → led and busy drop immediately. After release, a start begins a fresh WAIT with the prescaler at 0.
- Hold start high for 100 cycles in IDLE → exactly one WAIT entry (edge detect).

Source files
------------

// File: rtl/reaction_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared types and helpers for the reaction-timer control unit.
//   state_t       : controller states
//   disp_mode_t   : display mode code handed to the 7-segment scanner
//   LFSR_TAPS     : feedback mask for the 16-bit Fibonacci LFSR (x^16+x^15+x^13+x^4)
//   to_bcd()      : elaboration-time binary -> 4-digit BCD conversion
// -----------------------------------------------------------------------------
package reaction_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      TIMING = 3'd2,
      DONE   = 3'd3,
      CHEAT  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      DM_IDLE_MSG = 2'd0,
      DM_COUNT    = 2'd1,
      DM_CHEAT    = 2'd2,
      DM_BLANK    = 2'd3
   } disp_mode_t;

   localparam int unsigned BCD_W         = 16;
   localparam logic [15:0] LFSR_TAPS     = 16'hD008;
   localparam logic [15:0] BCD_ALL_NINES = 16'h9999;

   function automatic logic [BCD_W-1:0] to_bcd(input int unsigned value);
      int unsigned      rem;
      logic [BCD_W-1:0] res;
      rem = value;
      res = '0;
      for (int i = 0; i < BCD_W / 4; i++) begin
         res[i*4 +: 4] = 4'(rem % 10);
         rem           = rem / 10;
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_counter4.sv
// -----------------------------------------------------------------------------
// bcd_counter4
// Four-digit BCD up-counter with synchronous clear; wraps 9999 -> 0000.
// Ports:
//   clk     in   clock
//   reset_n in   asynchronous active-low reset (count -> 0)
//   clr     in   synchronous clear, dominates inc
//   inc     in   count up by one, carrying digit-wise 9 -> 0
//   q       out  {thousands, hundreds, tens, ones}
//   at_max  out  high when q == 9999
// -----------------------------------------------------------------------------
module bcd_counter4
   import reaction_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] q,
   output logic             at_max
);

   logic [BCD_W-1:0] q_q;
   logic [BCD_W-1:0] q_d;
   logic [BCD_W-1:0] q_inc;
   logic             carry;

   // Ripple the +1 through the digits; a digit only moves if every lower
   // digit rolled over from 9.
   always_comb begin
      q_inc = q_q;
      carry = 1'b1;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (carry) begin
            if (q_q[i*4 +: 4] == 4'd9) begin
               q_inc[i*4 +: 4] = 4'd0;
            end else begin
               q_inc[i*4 +: 4] = q_q[i*4 +: 4] + 4'd1;
               carry           = 1'b0;
            end
         end
      end
   end

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc) begin
         q_d = q_inc;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q      = q_q;
   assign at_max = (q_q == BCD_ALL_NINES);

endmodule

// File: rtl/reaction_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// reaction_ctrl_fsm
// Control unit of the reaction-timer game: idle -> random wait -> stimulus LED
// with millisecond timing -> result. Produces BCD result digits and a display
// mode for the downstream 7-segment scanner (no scanning in here).
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   start     in   debounced level, rising edge = event
//   stop      in   debounced level, rising edge = event
//   clear     in   debounced level, rising edge = event
//   led       out  stimulus LED, high only while timing
//   bcd       out  result digits {thousands, hundreds, tens, ones}
//   disp_mode out  0=HI message, 1=show bcd, 2=cheat, 3=blank
//   busy      out  high while waiting or timing
// All outputs decode from registers only; buttons never reach an output
// combinationally.
// -----------------------------------------------------------------------------
module reaction_ctrl_fsm
   import reaction_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 100000,
   parameter int unsigned MIN_DELAY_MS = 2000,
   parameter int unsigned RAND_BITS    = 11,
   parameter int unsigned TIMEOUT_MS   = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   output logic        led,
   output logic [15:0] bcd,
   output logic [1:0]  disp_mode,
   output logic        busy
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS)) + 1;
   // Count value one tick before the timeout; the tick that leaves it is the
   // one that lands on TIMEOUT_MS.
   localparam logic [BCD_W-1:0] TO_LAST_BCD = to_bcd(TIMEOUT_MS - 1);

   state_t          state_q, state_d;
   logic            start_q, stop_q, clear_q;
   logic            start_ev, stop_ev, clear_ev;
   logic [15:0]     lfsr_q, lfsr_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            tick;
   logic [DW-1:0]   ms_q, ms_d;
   logic [DW-1:0]   delay_q, delay_d;
   logic [BCD_W-1:0] cnt_q;
   logic            cnt_clr, cnt_inc, cnt_at_max;
   disp_mode_t      dm;

   assign start_ev = start & ~start_q;
   assign stop_ev  = stop  & ~stop_q;
   assign clear_ev = clear & ~clear_q;

   assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   assign tick   = (presc_q == PW'(TICK_DIV - 1));

   // Next state. Event priority is clear > stop > start wherever more than
   // one of them has an effect in the current state.
   always_comb begin
      state_d = state_q;
      ms_d    = ms_q;
      delay_d = delay_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (!clear_ev && start_ev) begin
               state_d = WAIT;
               delay_d = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);
               ms_d    = '0;
            end
         end
         WAIT: begin
            if (clear_ev) begin
               state_d = IDLE;
            end else if (stop_ev) begin
               state_d = CHEAT;
            end else if (tick) begin
               if (ms_q == delay_q - DW'(1)) begin
                  state_d = TIMING;
                  cnt_clr = 1'b1;
               end else begin
                  ms_d = ms_q + DW'(1);
               end
            end
         end
         TIMING: begin
            if (clear_ev) begin
               state_d = IDLE;
            end else if (stop_ev) begin
               // A tick landing on the stop edge is dropped: the count freezes.
               state_d = DONE;
            end else if (tick) begin
               cnt_inc = !cnt_at_max;
               if (cnt_q == TO_LAST_BCD) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (clear_ev) begin
               state_d = IDLE;
            end else if (start_ev) begin
               state_d = WAIT;
               delay_d = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);
               ms_d    = '0;
            end
         end
         CHEAT: begin
            if (clear_ev) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Returning to idle always blanks the result.
      if (state_d == IDLE && state_q != IDLE) begin
         cnt_clr = 1'b1;
      end
   end

   // Prescaler restarts on every state change so each state's first tick
   // is a full millisecond after entry.
   always_comb begin
      presc_d = presc_q + PW'(1);
      if (state_d != state_q || tick) begin
         presc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         clear_q <= 1'b0;
         lfsr_q  <= 16'h0001;
         presc_q <= '0;
         ms_q    <= '0;
         delay_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         stop_q  <= stop;
         clear_q <= clear;
         lfsr_q  <= lfsr_d;
         presc_q <= presc_d;
         ms_q    <= ms_d;
         delay_q <= delay_d;
      end
   end

   bcd_counter4 u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .q       (cnt_q),
      .at_max  (cnt_at_max)
   );

   always_comb begin
      dm = DM_IDLE_MSG;
      case (state_q)
         IDLE:    dm = DM_IDLE_MSG;
         WAIT:    dm = DM_BLANK;
         TIMING:  dm = DM_COUNT;
         DONE:    dm = DM_COUNT;
         CHEAT:   dm = DM_CHEAT;
         default: dm = DM_IDLE_MSG;
      endcase
   end

   assign disp_mode = dm;
   assign led       = (state_q == TIMING);
   assign busy      = (state_q == WAIT) || (state_q == TIMING);
   assign bcd       = (state_q == CHEAT) ? BCD_ALL_NINES : cnt_q;

endmodule

// File: tb/tb_reaction_ctrl_fsm.sv
module tb_reaction_ctrl_fsm;

   logic        clk;
   logic        reset_n;
   logic        start, stop, clear;
   logic        led;
   logic [15:0] bcd;
   logic [1:0]  disp_mode;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] m_lfsr;

   reaction_ctrl_fsm #(
      .TICK_DIV     (4),
      .MIN_DELAY_MS (3),
      .RAND_BITS    (2),
      .TIMEOUT_MS   (12)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .stop      (stop),
      .clear     (clear),
      .led       (led),
      .bcd       (bcd),
      .disp_mode (disp_mode),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: x^16 + x^15 + x^13 + x^4, shift left, feedback into bit 0.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m_lfsr <= 16'h0001;
      else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic press(input logic s, input logic p, input logic c);
      start = s; stop = p; clear = c;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; clear = 1'b0;
   endtask

   task automatic wait_led(output int k);
      k = 0;
      while (led !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
   endtask

   // Start from IDLE/DONE and return on the first sample with led high.
   task automatic run_to_timing(input string tag);
      int k;
      int exp_k;
      exp_k = 4 * (3 + int'(m_lfsr[1:0]));
      press(1'b1, 1'b0, 1'b0);
      check({tag, "_busy"},  32'(busy), 32'd1);
      check({tag, "_disp"},  32'(disp_mode), 32'd3);
      check({tag, "_led0"},  32'(led), 32'd0);
      check({tag, "_presc"}, 32'(dut.presc_q), 32'd0);
      wait_led(k);
      check({tag, "_led_delay"}, 32'(k), 32'(exp_k));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int bad;
      int entries;
      logic prev;

      reset_n = 1'b0;
      start = 1'b0; stop = 1'b0; clear = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_led",  32'(led), 32'd0);
      check("rst_bcd",  32'(bcd), 32'd0);
      check("rst_disp", 32'(disp_mode), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;

      // Idle for 20 cycles, LFSR tracking the reference and never zero
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (dut.lfsr_q == 16'h0 || dut.lfsr_q !== m_lfsr) bad++;
      end
      check("idle_lfsr", 32'(bad), 32'd0);
      check("idle_led",  32'(led), 32'd0);
      check("idle_bcd",  32'(bcd), 32'd0);
      check("idle_disp", 32'(disp_mode), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Normal round: stop 22 cycles after led rises -> 5 ticks
      run_to_timing("r1");
      repeat (21) @(negedge clk);
      press(1'b0, 1'b1, 1'b0);
      check("r1_bcd",  32'(bcd), 32'h0005);
      check("r1_disp", 32'(disp_mode), 32'd1);
      check("r1_led",  32'(led), 32'd0);
      check("r1_busy", 32'(busy), 32'd0);
      repeat (10) @(negedge clk);
      check("r1_hold", 32'(bcd), 32'h0005);

      // Clear from DONE, then cheat
      press(1'b0, 1'b0, 1'b1);
      check("clr_disp", 32'(disp_mode), 32'd0);
      check("clr_bcd",  32'(bcd), 32'd0);
      press(1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      press(1'b0, 1'b1, 1'b0);
      check("cheat_bcd",  32'(bcd), 32'h9999);
      check("cheat_disp", 32'(disp_mode), 32'd2);
      check("cheat_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      press(1'b1, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      check("cheat_start_disp", 32'(disp_mode), 32'd2);
      check("cheat_start_led",  32'(led), 32'd0);
      press(1'b0, 1'b0, 1'b1);
      check("cheat_clr_disp", 32'(disp_mode), 32'd0);
      check("cheat_clr_bcd",  32'(bcd), 32'd0);

      // Timeout after 12 ticks
      run_to_timing("to");
      repeat (47) @(negedge clk);
      check("to_pre_led", 32'(led), 32'd1);
      check("to_pre_bcd", 32'(bcd), 32'h0011);
      @(negedge clk);
      check("to_led",  32'(led), 32'd0);
      check("to_bcd",  32'(bcd), 32'h0012);
      check("to_disp", 32'(disp_mode), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      repeat (8) @(negedge clk);
      check("to_hold", 32'(bcd), 32'h0012);

      // Stop coinciding with the 6th tick: that tick is dropped
      run_to_timing("co");
      repeat (23) @(negedge clk);
      press(1'b0, 1'b1, 1'b0);
      check("co_bcd", 32'(bcd), 32'h0005);

      // Clear and stop together in TIMING -> clear wins
      run_to_timing("cs");
      repeat (5) @(negedge clk);
      check("cs_pre_bcd", 32'(bcd), 32'h0001);
      press(1'b0, 1'b1, 1'b1);
      check("cs_disp", 32'(disp_mode), 32'd0);
      check("cs_bcd",  32'(bcd), 32'd0);
      check("cs_led",  32'(led), 32'd0);

      // Start and stop together in DONE -> start wins
      run_to_timing("ss");
      repeat (6) @(negedge clk);
      press(1'b0, 1'b1, 1'b0);
      check("ss_done_bcd", 32'(bcd), 32'h0001);
      repeat (2) @(negedge clk);
      press(1'b1, 1'b1, 1'b0);
      check("ss_busy", 32'(busy), 32'd1);
      check("ss_disp", 32'(disp_mode), 32'd3);

      // Async reset mid-TIMING
      begin
         int k;
         wait_led(k);
         check("ar_in_timing", 32'(led), 32'd1);
      end
      repeat (3) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_led",  32'(led), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_disp", 32'(disp_mode), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_to_timing("ar");

      // Held start: exactly one WAIT entry
      press(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      start   = 1'b1;
      prev    = busy;
      entries = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy && !prev) entries++;
         prev = busy;
      end
      start = 1'b0;
      check("hold_entries", 32'(entries), 32'd1);
      check("hold_disp",    32'(disp_mode), 32'd1);
      check("hold_bcd",     32'(bcd), 32'h0012);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
